// File: rtl/fmap_stream_src_pkg.sv
// Shared definitions for the feature-map stream source: default pixel geometry,
// FSM state type and width helpers.
package fmap_stream_src_pkg;

  localparam int FMAP_I_BW   = 8;
  localparam int FMAP_I_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_END = 2'd2
  } fmap_state_t;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_stream_src_skid_buf.sv
// fmap_skid_buf: 2-entry valid/ready skid register with a registered output
// stage. The feeder must not push while level==2 and no pop is pending.
module fmap_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   level
);

  logic         main_v, skid_v;
  logic [W-1:0] main_d, skid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (ce) begin
      if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (!main_v || out_ready) begin
        if (skid_v) begin
          main_d <= skid_d;
          main_v <= 1'b1;
          skid_v <= in_valid;
          if (in_valid) skid_d <= in_data;
        end else begin
          main_v <= in_valid;
          if (in_valid) main_d <= in_data;
        end
      end else if (in_valid && !skid_v) begin
        skid_v <= 1'b1;
        skid_d <= in_data;
      end
    end
  end

  assign out_valid = main_v;
  assign out_data  = main_d;
  assign level     = 2'(main_v) + 2'(skid_v);

endmodule

// File: rtl/fmap_stream_src.sv
// fmap_stream_src: on-chip image buffer streaming a selected image in raster
// order over valid/ready. Optional FMAP_STREAM_AUTOLOOP_EN cycles through images.
module fmap_stream_src
  import fmap_stream_src_pkg::*;
#(
  parameter int   I_BW        = FMAP_I_BW,
  parameter int   I_SIZE      = FMAP_I_SIZE,
  parameter int   I_CH        = 1,
  parameter int   N_IMG       = 4,
  localparam int  PIX_PER_IMG = I_SIZE * I_SIZE * I_CH,
  localparam int  AW          = clog2(N_IMG * PIX_PER_IMG),
  localparam int  SW          = idx_w(N_IMG)
) (
  input  logic            clk,
  input  logic            global_rst_n,
  input  logic            ce,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [I_BW-1:0] i_wr_data,
  input  logic            i_start,
  input  logic [SW-1:0]   i_img_sel,
  input  logic            i_fmap_ready,
  input  logic            i_rst_processEnd,
  output logic [I_BW-1:0] o_fmap,
  output logic            o_fmap_valid,
  output logic            o_first,
  output logic            o_last,
  output logic            o_busy,
  output logic            o_done
);

  localparam int PW = idx_w(PIX_PER_IMG);
  localparam int CW = idx_w(I_SIZE);
  localparam int HW = idx_w(I_CH);

  fmap_state_t     state;
  logic [SW-1:0]   img;
  logic [PW-1:0]   pix;
  logic [CW-1:0]   col, row;
  logic [HW-1:0]   ch;
  logic            issued_all;
  logic            rd_vld, rd_first, rd_last;
  logic [I_BW-1:0] rd_data;
  logic [I_BW-1:0] mem [N_IMG * PIX_PER_IMG];
`ifdef FMAP_STREAM_AUTOLOOP_EN
  logic            stop_req;
`endif

  logic [I_BW+1:0] sk_out;
  logic [1:0]      sk_lvl;
  logic            pop, abort, issue, end_beat;
  logic [2:0]      occ;
  logic [AW-1:0]   base, rd_addr;
  logic [SW-1:0]   sel_c;

  always_comb begin
    sel_c = i_img_sel;
    if (32'(i_img_sel) > 32'(N_IMG - 1)) sel_c = SW'(N_IMG - 1);
  end

  assign pop      = o_fmap_valid & i_fmap_ready;
  assign abort    = (state == STREAM) & i_rst_processEnd;
  assign end_beat = pop & o_last;
  // Credit check: skid entries after this edge plus the read now in flight
  // must never exceed the two skid slots.
  assign occ      = 3'(sk_lvl) + 3'(rd_vld) - 3'(pop);
  assign issue    = (state == STREAM) & ~issued_all & ~i_rst_processEnd & (occ <= 3'd1);
  assign base     = AW'(img) * AW'(PIX_PER_IMG);
  assign rd_addr  = base + AW'(pix);

  always_ff @(posedge clk) begin
    if (ce) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
      if (issue)   rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state      <= IDLE;
      img        <= '0;
      pix        <= '0;
      col        <= '0;
      row        <= '0;
      ch         <= '0;
      issued_all <= 1'b0;
      rd_vld     <= 1'b0;
      rd_first   <= 1'b0;
      rd_last    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef FMAP_STREAM_AUTOLOOP_EN
      stop_req   <= 1'b0;
`endif
    end else if (ce) begin
      o_done   <= 1'b0;
      rd_vld   <= issue;
      rd_first <= issue & (col == '0) & (row == '0);
      rd_last  <= issue & (pix == PW'(PIX_PER_IMG - 1));
      if (issue) begin
        if (pix == PW'(PIX_PER_IMG - 1)) issued_all <= 1'b1;
        else                             pix <= pix + 1'b1;
        if (col == CW'(I_SIZE - 1)) begin
          col <= '0;
          if (row == CW'(I_SIZE - 1)) begin
            row <= '0;
            ch  <= (ch == HW'(I_CH - 1)) ? '0 : ch + 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= STREAM;
            o_busy     <= 1'b1;
            img        <= sel_c;
            pix        <= '0;
            col        <= '0;
            row        <= '0;
            ch         <= '0;
            issued_all <= 1'b0;
`ifdef FMAP_STREAM_AUTOLOOP_EN
            stop_req   <= 1'b0;
`endif
          end
        end
        STREAM: begin
          if (i_rst_processEnd) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            rd_vld <= 1'b0;
          end else if (end_beat) begin
            state <= WAIT_END;
          end
`ifdef FMAP_STREAM_AUTOLOOP_EN
          if (i_start) stop_req <= 1'b1;
`endif
        end
        WAIT_END: begin
`ifdef FMAP_STREAM_AUTOLOOP_EN
          if (i_rst_processEnd) begin
            o_done <= 1'b1;
            if (stop_req || i_start) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state      <= STREAM;
              img        <= (img == SW'(N_IMG - 1)) ? '0 : img + 1'b1;
              pix        <= '0;
              col        <= '0;
              row        <= '0;
              ch         <= '0;
              issued_all <= 1'b0;
            end
          end else if (i_start) begin
            stop_req <= 1'b1;
          end
`else
          if (i_rst_processEnd) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  fmap_skid_buf #(
    .W(I_BW + 2)
  ) u_skid (
    .clk      (clk),
    .rst_n    (global_rst_n),
    .ce       (ce),
    .flush    (abort),
    .in_valid (rd_vld),
    .in_data  ({rd_first, rd_last, rd_data}),
    .out_valid(o_fmap_valid),
    .out_data (sk_out),
    .out_ready(i_fmap_ready),
    .level    (sk_lvl)
  );

  assign o_fmap  = sk_out[I_BW-1:0];
  assign o_last  = o_fmap_valid & sk_out[I_BW];
  assign o_first = o_fmap_valid & sk_out[I_BW+1];

endmodule

// File: doc/fmap_stream_src.md
Name: fmap_stream_src

Overview:
- Synthesizable feature-map source for the lenet5 input port.
- Replaces the bench-only pixel feeder with an on-chip image buffer.
- Holds N_IMG preloaded images of I_CH channels, I_SIZE x I_SIZE pixels each, and streams a selected image in raster order over a valid/ready handshake.
- Sits between a host load port and the first convolution stage; gated by ce.

Parameters:
- I_BW, 8, pixel width in bits
- I_SIZE, 32, image side length in pixels
- I_CH, 1, channels per image
- N_IMG, 4, images held in buffer
- PIX_PER_IMG, I_SIZE*I_SIZE*I_CH, derived localparam, not overridable
- AW, clog2(N_IMG*PIX_PER_IMG), derived buffer address width

Ports:
- clk  in  1  system clock
- global_rst_n  in  1  reset, asynchronous, active-low
- ce  in  1  clock enable; when low, all state holds
- i_wr_en  in  1  buffer write strobe
- i_wr_addr  in  AW  buffer write address (image-major, channel, row, column)
- i_wr_data  in  I_BW  buffer write data
- i_start  in  1  start-stream pulse
- i_img_sel  in  clog2(N_IMG)  image to stream; sampled with i_start
- i_fmap_ready  in  1  consumer ready
- i_rst_processEnd  in  1  downstream classification finished
- o_fmap  out  I_BW  pixel data
- o_fmap_valid  out  1  pixel valid
- o_first  out  1  first pixel of a channel plane, qualified by valid
- o_last  out  1  last pixel of the image, qualified by valid
- o_busy  out  1  stream in progress or awaiting process end
- o_done  out  1  one-cycle pulse when i_rst_processEnd is accepted

Behaviour:
- Decided interface: one clock, clk; reset global_rst_n is asynchronous, active-low.
- Reset values: o_fmap=0, o_fmap_valid=0, o_first=0, o_last=0, o_busy=0, o_done=0; FSM in IDLE; counters 0. Buffer contents are not reset.
- ce=0 freezes the FSM, counters, output register and buffer writes; outputs hold.
- Buffer: single simple-dual-port RAM with 1-cycle synchronous read. Writes are allowed in any state. A write to the address being read returns old data.
- FSM:
  - IDLE: i_start -> STREAM. Latch base = i_img_sel*PIX_PER_IMG; clear pixel, column, row and channel counters. If i_img_sel>=N_IMG, clamp to N_IMG-1.
  - STREAM: issue reads in order col -> row -> ch. A 2-entry skid output stage guarantees one pixel per cycle with no bubbles while i_fmap_ready=1.
    - First o_fmap_valid occurs 2 cycles after i_start.
    - o_fmap and the flags stay stable while valid=1 and ready=0.
    - When the last pixel handshakes -> WAIT_END.
  - WAIT_END: wait for i_rst_processEnd=1 -> pulse o_done, go to IDLE.
- i_start is ignored outside IDLE.
- o_first is 1 when col=0 and row=0, i.e. once per channel.
- o_last is 1 only on pixel PIX_PER_IMG-1.
- o_busy = (state != IDLE).
- i_rst_processEnd arriving in STREAM: abort. Flush the skid stage, drop valid next cycle, pulse o_done, go to IDLE.
- i_rst_processEnd in IDLE: ignored, no o_done.
- Simultaneous i_start and i_rst_processEnd in IDLE: start wins.
- Reset mid-stream: immediate return to IDLE, valid drops asynchronously.
- Counters wrap only at their own limits: col at I_SIZE-1, row at I_SIZE-1, ch at I_CH-1. No arithmetic overflow is permitted, since AW covers N_IMG*PIX_PER_IMG-1.

Optional Feature:
- Macro: FMAP_STREAM_AUTOLOOP_EN.
- Defined: in WAIT_END, i_rst_processEnd pulses o_done, increments the image index modulo N_IMG, and re-enters STREAM directly with no i_start. Streaming stops only when i_start is asserted while busy, which acts as a stop request: the FSM returns to IDLE after the current image's end.
- Undefined: behaviour as above, with one image per i_start.

Decomposition:
- Shared package/header (param_clog2.vh plus additions): I_BW, I_SIZE, clog2 function, state encoding localparams (IDLE=2'd0, STREAM=2'd1, WAIT_END=2'd2).
- One natural sub-module: fmap_skid_buf, a 2-entry valid/ready skid register parameterised by width. It carries {first, last, data}.
- Buffer RAM is inferred inline.

Test Plan:
- Reset/idle: global_rst_n low mid-cycle -> all outputs 0 immediately; o_busy=0 after release.
- Full stream: I_SIZE=4, I_CH=2, N_IMG=2; load image 1 with value = address; i_start with i_img_sel=1, ready always 1 -> 32 consecutive valid beats carrying 32..63, no gaps. o_first on beats 0 and 16; o_last on beat 31; first valid 2 cycles after start.
- Backpressure: toggle ready randomly at 50% -> identical 32-word sequence; data stable while stalled.
- ce gating: ce=0 for 5 cycles mid-stream -> no state or output change; stream resumes at the same pixel.
- Abort: assert i_rst_processEnd after beat 10 -> valid low next cycle, o_done pulses once, o_busy=0. A new i_start restarts at pixel 0.
- Autoloop (FMAP_STREAM_AUTOLOOP_EN): two processEnd pulses -> images 0, 1, 0 streamed in sequence, with o_done pulsing each time.
